// File: rtl/clkspec_sharedadd_n.sv
// N-client shared adder: each client hands an (a,b) pair over valid/ready, a round-robin
// arbiter feeds one adder, and the sum returns on that client's result handshake.
// Build option: define SHRES_SAT_EN to saturate the sum instead of wrapping it.
`timescale 1ns/1ps
module clkspec_sharedadd_n #(
    parameter  int WIDTH   = 4,
    parameter  int NCLIENT = 2,
    localparam int IDW     = $clog2(NCLIENT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCLIENT*WIDTH-1:0] c_ain,
    input  logic [NCLIENT*WIDTH-1:0] c_bin,
    input  logic [NCLIENT-1:0]       c_valid,
    output logic [NCLIENT-1:0]       c_ready,
    output logic [NCLIENT*WIDTH-1:0] c_yout,
    output logic [NCLIENT-1:0]       c_yvalid,
    input  logic [NCLIENT-1:0]       c_yready,
    output logic                     sh_busy,
    output logic [IDW-1:0]           sh_tag
);

    typedef enum logic [1:0] {C_IDLE, C_REQ, C_WAIT, C_OUT} client_state_e;
    typedef enum logic {SH_IDLE, SH_DONE} shared_state_e;

    client_state_e    cst_q [NCLIENT];
    client_state_e    cst_d [NCLIENT];
    logic [WIDTH-1:0] a_q   [NCLIENT];
    logic [WIDTH-1:0] a_d   [NCLIENT];
    logic [WIDTH-1:0] b_q   [NCLIENT];
    logic [WIDTH-1:0] b_d   [NCLIENT];
    logic [WIDTH-1:0] res_q [NCLIENT];
    logic [WIDTH-1:0] res_d [NCLIENT];

    shared_state_e    sh_q, sh_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   tag_q, tag_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;

    logic [NCLIENT-1:0] req;
    logic [NCLIENT-1:0] gnt;
    logic               gnt_any;
    logic [IDW-1:0]     gnt_idx;
    logic [WIDTH-1:0]   sum;
    logic               deliver;

    // Round-robin scan starts just after the last served client, so it ranks last next time.
    always_comb begin : arbiter
        int             idx;
        logic [IDW-1:0] cand;
        // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
        idx     = 0;
        cand    = '0;
        req     = '0;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NCLIENT; i++) begin
            req[i] = (cst_q[i] == C_REQ);
        end
        if (sh_q == SH_IDLE) begin
            for (int k = 1; k <= NCLIENT; k++) begin
                idx  = (int'(ptr_q) + k) % NCLIENT;
                cand = IDW'(idx);
                if (!gnt_any && req[cand]) begin
                    gnt_any   = 1'b1;
                    gnt_idx   = cand;
                    gnt[cand] = 1'b1;
                end
            end
        end
    end

`ifdef SHRES_SAT_EN
    logic [WIDTH:0] sum_full;
    always_comb begin : adder
        sum_full = {1'b0, sa_q} + {1'b0, sb_q};
        sum      = sum_full[WIDTH] ? '1 : sum_full[WIDTH-1:0];
    end
`else
    always_comb begin : adder
        sum = sa_q + sb_q;
    end
`endif

    assign deliver = (sh_q == SH_DONE);

    always_comb begin : shared_next
        sh_d  = sh_q;
        ptr_d = ptr_q;
        tag_d = tag_q;
        sa_d  = sa_q;
        sb_d  = sb_q;
        case (sh_q)
            SH_IDLE: begin
                if (gnt_any) begin
                    sh_d  = SH_DONE;
                    tag_d = gnt_idx;
                    sa_d  = a_q[gnt_idx];
                    sb_d  = b_q[gnt_idx];
                end
            end
            SH_DONE: begin
                sh_d  = SH_IDLE;
                ptr_d = tag_q;
            end
            default: sh_d = SH_IDLE;
        endcase
    end

    always_comb begin : client_next
        for (int i = 0; i < NCLIENT; i++) begin
            cst_d[i] = cst_q[i];
            a_d[i]   = a_q[i];
            b_d[i]   = b_q[i];
            res_d[i] = res_q[i];
            case (cst_q[i])
                C_IDLE: begin
                    if (c_valid[i]) begin
                        a_d[i]   = c_ain[i*WIDTH +: WIDTH];
                        b_d[i]   = c_bin[i*WIDTH +: WIDTH];
                        cst_d[i] = C_REQ;
                    end
                end
                C_REQ: begin
                    if (gnt[i]) cst_d[i] = C_WAIT;
                end
                C_WAIT: begin
                    if (deliver && (tag_q == IDW'(i))) begin
                        res_d[i] = sum;
                        cst_d[i] = C_OUT;
                    end
                end
                C_OUT: begin
                    if (c_yready[i]) cst_d[i] = C_IDLE;
                end
                default: cst_d[i] = C_IDLE;
            endcase
        end
    end

    // Handshake outputs decode directly from the state flops; no input-to-output paths.
    always_comb begin : outputs
        c_ready  = '0;
        c_yvalid = '0;
        c_yout   = '0;
        for (int i = 0; i < NCLIENT; i++) begin
            c_ready[i]                 = (cst_q[i] == C_IDLE);
            c_yvalid[i]                = (cst_q[i] == C_OUT);
            c_yout[i*WIDTH +: WIDTH]   = res_q[i];
        end
    end

    assign sh_busy = (sh_q == SH_DONE);
    assign sh_tag  = tag_q;

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sh_q  <= SH_IDLE;
            ptr_q <= IDW'(NCLIENT - 1);
            tag_q <= '0;
            sa_q  <= '0;
            sb_q  <= '0;
            // NOTE: the per-client register arrays are small and observable on c_yout, so they are reset.
            for (int i = 0; i < NCLIENT; i++) begin
                cst_q[i] <= C_IDLE;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                res_q[i] <= '0;
            end
        end else begin
            sh_q  <= sh_d;
            ptr_q <= ptr_d;
            tag_q <= tag_d;
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            for (int i = 0; i < NCLIENT; i++) begin
                cst_q[i] <= cst_d[i];
                a_q[i]   <= a_d[i];
                b_q[i]   <= b_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

endmodule
